schl_cpu_fetch_sched: RTL and testbench

Multi-thread instruction-fetch scheduler for the schl_cpu. It owns both read ports of schl_cpu_instr_rom and arbitrates round-robin among up to N_THR thread contexts, issuing up to two fetches per cycle, one per ROM port. Each port feeds one output lane to the decode/execute stage with valid/ready backpressure. Execute returns a completion per instruction with the thread's next PC or a halt, which makes that thread eligible again.

---
 rtl/schl_cpu_fetch_sched.sv | 179 +++++++++++++++++
 tb/tb_schl_cpu_fetch_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/schl_cpu_fetch_sched.sv
// Multi-thread instruction-fetch scheduler for schl_cpu.
// Round-robin grants READY threads onto two ROM read ports; each ROM output
// register doubles as the holding register of its output lane.
module schl_cpu_fetch_sched #(
  parameter int ROM_WIDTH   = 64,
  parameter int ROM_DEPTH   = 4096,
  parameter int W_ROM_DEPTH = $clog2(ROM_DEPTH),
  parameter int N_THR       = 4,
  parameter int W_THR       = $clog2(N_THR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [W_THR-1:0]       start_thr,
  input  logic [W_ROM_DEPTH-1:0] start_pc,
  output logic [W_ROM_DEPTH-1:0] rom_a_addr,
  output logic                   rom_a_en,
  input  logic [ROM_WIDTH-1:0]   rom_a_data,
  output logic [W_ROM_DEPTH-1:0] rom_b_addr,
  output logic                   rom_b_en,
  input  logic [ROM_WIDTH-1:0]   rom_b_data,
  output logic                   o0_valid,
  input  logic                   o0_ready,
  output logic [W_THR-1:0]       o0_thr,
  output logic [W_ROM_DEPTH-1:0] o0_pc,
  output logic [ROM_WIDTH-1:0]   o0_instr,
  output logic                   o1_valid,
  input  logic                   o1_ready,
  output logic [W_THR-1:0]       o1_thr,
  output logic [W_ROM_DEPTH-1:0] o1_pc,
  output logic [ROM_WIDTH-1:0]   o1_instr,
  input  logic                   done_valid,
  input  logic [W_THR-1:0]       done_thr,
  input  logic [W_ROM_DEPTH-1:0] done_pc,
  input  logic                   done_halt,
  output logic                   err,
  output logic [N_THR-1:0]       thr_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_BUSY  = 2'd2
  } thr_state_t;

  thr_state_t             r_state [N_THR];
  logic [W_ROM_DEPTH-1:0] r_pc    [N_THR];
  logic [W_THR-1:0]       r_rr_ptr;
  logic                   r_err;
  logic                   r_o0_valid, r_o1_valid;
  logic [W_THR-1:0]       r_o0_thr, r_o1_thr;
  logic [W_ROM_DEPTH-1:0] r_o0_pc, r_o1_pc;

  logic                   w_free0, w_free1;
  logic                   w_hit0, w_hit1;
  logic [W_THR-1:0]       w_h0, w_h1;
  logic [W_THR:0]         w_idx;
  logic                   w_gnt0, w_gnt1;
  logic [W_THR-1:0]       w_gnt0_thr, w_gnt1_thr, w_last_thr, w_rr_next;

  assign w_free0 = !r_o0_valid | o0_ready;
  assign w_free1 = !r_o1_valid | o1_ready;

  // Round-robin scan: first two READY threads from rr_ptr, mapped onto free lanes
  always_comb begin
    w_hit0 = 1'b0;
    w_hit1 = 1'b0;
    w_h0   = '0;
    w_h1   = '0;
    w_idx  = '0;
    for (int unsigned k = 0; k < N_THR; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (W_THR+1)'(k);
      if (w_idx >= (W_THR+1)'(N_THR)) w_idx = w_idx - (W_THR+1)'(N_THR);
      if (r_state[w_idx[W_THR-1:0]] == ST_READY) begin
        if (!w_hit0) begin
          w_hit0 = 1'b1;
          w_h0   = w_idx[W_THR-1:0];
        end else if (!w_hit1) begin
          w_hit1 = 1'b1;
          w_h1   = w_idx[W_THR-1:0];
        end
      end
    end
    w_gnt0     = w_hit0 & w_free0;
    w_gnt0_thr = w_h0;
    w_gnt1     = 1'b0;
    w_gnt1_thr = w_h1;
    if (w_free0) begin
      w_gnt1 = w_hit1 & w_free1;
    end else if (w_hit0 && w_free1) begin
      // lane 0 blocked: the first hit moves over to lane 1
      w_gnt1     = 1'b1;
      w_gnt1_thr = w_h0;
    end
    w_last_thr = w_gnt1 ? w_gnt1_thr : w_gnt0_thr;
    w_rr_next  = (w_last_thr == W_THR'(N_THR-1)) ? '0 : w_last_thr + 1'b1;
  end

  assign rom_a_en    = w_gnt0;
  assign rom_a_addr  = w_gnt0 ? r_pc[w_gnt0_thr] : '0;
  assign rom_b_en    = w_gnt1;
  assign rom_b_addr  = w_gnt1 ? r_pc[w_gnt1_thr] : '0;
  assign start_ready = rst & (r_state[start_thr] == ST_IDLE);

  // Per-thread context FSM, round-robin pointer and sticky protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_THR; i++) begin
        r_state[W_THR'(i)] <= ST_IDLE;
        r_pc[W_THR'(i)]    <= '0;
      end
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_gnt0) r_state[w_gnt0_thr] <= ST_BUSY;
      if (w_gnt1) r_state[w_gnt1_thr] <= ST_BUSY;
      if (done_valid) begin
        if (r_state[done_thr] == ST_BUSY) begin
          r_state[done_thr] <= done_halt ? ST_IDLE : ST_READY;
          if (!done_halt) r_pc[done_thr] <= done_pc;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (start_valid && start_ready) begin
        r_state[start_thr] <= ST_READY;
        r_pc[start_thr]    <= start_pc;
      end
      if (w_gnt0 || w_gnt1) r_rr_ptr <= w_rr_next;
    end
  end

  // Lane tag registers; valid survives a handshake only with a same-cycle re-issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_o0_valid <= 1'b0;
      r_o0_thr   <= '0;
      r_o0_pc    <= '0;
      r_o1_valid <= 1'b0;
      r_o1_thr   <= '0;
      r_o1_pc    <= '0;
    end else begin
      if (w_gnt0) begin
        r_o0_valid <= 1'b1;
        r_o0_thr   <= w_gnt0_thr;
        r_o0_pc    <= r_pc[w_gnt0_thr];
      end else if (o0_ready) begin
        r_o0_valid <= 1'b0;
      end
      if (w_gnt1) begin
        r_o1_valid <= 1'b1;
        r_o1_thr   <= w_gnt1_thr;
        r_o1_pc    <= r_pc[w_gnt1_thr];
      end else if (o1_ready) begin
        r_o1_valid <= 1'b0;
      end
    end
  end

  // Busy bitmap: any context not IDLE
  always_comb begin
    thr_busy = '0;
    for (int unsigned i = 0; i < N_THR; i++) begin
      thr_busy[W_THR'(i)] = (r_state[W_THR'(i)] != ST_IDLE);
    end
  end

  assign o0_valid = r_o0_valid;
  assign o0_thr   = r_o0_thr;
  assign o0_pc    = r_o0_pc;
  assign o0_instr = rom_a_data;
  assign o1_valid = r_o1_valid;
  assign o1_thr   = r_o1_thr;
  assign o1_pc    = r_o1_pc;
  assign o1_instr = rom_b_data;
  assign err      = r_err;

endmodule

// File: tb/tb_schl_cpu_fetch_sched.sv
// Bench for schl_cpu_fetch_sched: directed scenarios plus randomized traffic
// against a queue-based model of thread states and lane occupancy.
module tb_schl_cpu_fetch_sched;
  localparam int RW = 64, RD = 4096, AW = 12, NT = 4, TW = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic start_valid, start_ready;
  logic [TW-1:0] start_thr;
  logic [AW-1:0] start_pc;
  logic [AW-1:0] rom_a_addr, rom_b_addr;
  logic rom_a_en, rom_b_en;
  logic [RW-1:0] rom_a_data = '0, rom_b_data = '0;
  logic o0_valid, o1_valid, o0_ready, o1_ready;
  logic [TW-1:0] o0_thr, o1_thr;
  logic [AW-1:0] o0_pc, o1_pc;
  logic [RW-1:0] o0_instr, o1_instr;
  logic done_valid, done_halt;
  logic [TW-1:0] done_thr;
  logic [AW-1:0] done_pc;
  logic err;
  logic [NT-1:0] thr_busy;
  logic [RW-1:0] rom [RD];
  int n_chk = 0, n_fail = 0;

  // model: thread state 0=IDLE 1=READY 2=BUSY, lane occupancy, rr pointer
  int m_st [NT];
  logic [AW-1:0] m_pc [NT];
  int m_rr;
  bit m_v [2];
  int m_thr [2];
  logic [AW-1:0] m_lpc [2];
  bit m_err;
  bit e_en [2];
  logic [AW-1:0] e_addr [2];
  int e_g [2];
  bit e_sr, e_any;
  int e_last;

  schl_cpu_fetch_sched #(.ROM_WIDTH(RW), .ROM_DEPTH(RD), .N_THR(NT)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_thr(start_thr), .start_pc(start_pc),
    .rom_a_addr(rom_a_addr), .rom_a_en(rom_a_en), .rom_a_data(rom_a_data),
    .rom_b_addr(rom_b_addr), .rom_b_en(rom_b_en), .rom_b_data(rom_b_data),
    .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_thr(o0_thr), .o0_pc(o0_pc), .o0_instr(o0_instr),
    .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_thr(o1_thr), .o1_pc(o1_pc), .o1_instr(o1_instr),
    .done_valid(done_valid), .done_thr(done_thr), .done_pc(done_pc), .done_halt(done_halt),
    .err(err), .thr_busy(thr_busy)
  );

  always #5 clk = ~clk;

  // ROM with 1-cycle latency; data holds while en is low
  always @(posedge clk) begin
    if (rom_a_en) rom_a_data <= rom[rom_a_addr];
    if (rom_b_en) rom_b_data <= rom[rom_b_addr];
  end

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin m_st[k] = 0; m_pc[k] = '0; end
    m_rr = 0; m_err = 0;
    for (int l = 0; l < 2; l++) begin m_v[l] = 0; m_thr[l] = 0; m_lpc[l] = '0; end
  endtask

  // READY threads in rotation order are handed to free lanes, lane 0 first
  task automatic model_eval();
    int rdy[$];
    bit fr [2];
    fr[0] = !m_v[0] || o0_ready;
    fr[1] = !m_v[1] || o1_ready;
    for (int k = 0; k < NT; k++) if (m_st[(m_rr + k) % NT] == 1) rdy.push_back((m_rr + k) % NT);
    e_any = 0; e_last = 0;
    for (int l = 0; l < 2; l++) begin
      e_en[l] = 0; e_addr[l] = '0; e_g[l] = 0;
      if (fr[l] && rdy.size() > 0) begin
        e_en[l] = 1; e_g[l] = rdy.pop_front(); e_addr[l] = m_pc[e_g[l]];
        e_any = 1; e_last = e_g[l];
      end
    end
    e_sr = (m_st[start_thr] == 0);
  endtask

  task automatic model_commit();
    int nst [NT];
    bit rd [2];
    nst = m_st;
    rd[0] = o0_ready; rd[1] = o1_ready;
    for (int l = 0; l < 2; l++) begin
      if (e_en[l]) begin nst[e_g[l]] = 2; m_v[l] = 1; m_thr[l] = e_g[l]; m_lpc[l] = e_addr[l]; end
      else if (rd[l]) m_v[l] = 0;
    end
    if (done_valid) begin
      if (m_st[done_thr] == 2) begin
        nst[done_thr] = done_halt ? 0 : 1;
        if (!done_halt) m_pc[done_thr] = done_pc;
      end else m_err = 1;
    end
    if (start_valid && e_sr) begin nst[start_thr] = 1; m_pc[start_thr] = start_pc; end
    m_st = nst;
    if (e_any) m_rr = (e_last + 1) % NT;
  endtask

  task automatic idle_in();
    start_valid = 0; start_thr = '0; start_pc = '0;
    done_valid = 0; done_thr = '0; done_pc = '0; done_halt = 0;
  endtask

  task automatic look(); #1; model_eval(); endtask
  task automatic step(); model_commit(); @(negedge clk); endtask

  task automatic apply_reset();
    idle_in(); rst = 0; #1; model_reset(); @(negedge clk); rst = 1;
  endtask

  task automatic test_reset();
    idle_in(); o0_ready = 1; o1_ready = 1; start_valid = 1; rst = 0; model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (start_ready !== 1'b0) begin n_fail++; $display("FAIL reset_start_ready got %0b exp 0", start_ready); end
    n_chk++; if ({rom_a_en, rom_b_en, o0_valid, o1_valid, err} !== 5'b0)
      begin n_fail++; $display("FAIL reset_flags got %b exp 00000", {rom_a_en, rom_b_en, o0_valid, o1_valid, err}); end
    n_chk++; if ({rom_a_addr, rom_b_addr, o0_pc, o1_pc, o0_thr, o1_thr, thr_busy} !== '0)
      begin n_fail++; $display("FAIL reset_values got a=%h b=%h p0=%h p1=%h t0=%0d t1=%0d busy=%b exp all 0", rom_a_addr, rom_b_addr, o0_pc, o1_pc, o0_thr, o1_thr, thr_busy); end
    @(negedge clk); rst = 1; start_valid = 0;
    look();
    n_chk++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_start_ready got %0b exp 1", start_ready); end
    step();
  endtask

  task automatic test_single_thread();
    o0_ready = 1; o1_ready = 1;
    idle_in(); start_valid = 1; start_thr = 0; start_pc = 12'h010; look();
    n_chk++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL single_start_ready got %0b exp 1", start_ready); end
    step();
    idle_in(); look();
    n_chk++; if ({rom_a_en, rom_b_en, rom_a_addr} !== {2'b10, 12'h010})
      begin n_fail++; $display("FAIL single_issue got en=%b%b addr=%h exp en=10 addr=010", rom_a_en, rom_b_en, rom_a_addr); end
    step();
    done_valid = 1; done_thr = 0; done_pc = 12'h011; look();
    n_chk++; if ({o0_valid, o0_thr, o0_pc} !== {1'b1, 2'd0, 12'h010})
      begin n_fail++; $display("FAIL single_lane got v=%0b thr=%0d pc=%h exp v=1 thr=0 pc=010", o0_valid, o0_thr, o0_pc); end
    n_chk++; if (o0_instr !== rom[12'h010]) begin n_fail++; $display("FAIL single_instr got %h exp %h", o0_instr, rom[12'h010]); end
    n_chk++; if (rom_a_en !== 1'b0) begin n_fail++; $display("FAIL single_no_refetch got %0b exp 0", rom_a_en); end
    step();
    idle_in(); look();
    n_chk++; if ({rom_a_en, rom_a_addr} !== {1'b1, 12'h011})
      begin n_fail++; $display("FAIL single_refetch got en=%0b addr=%h exp en=1 addr=011", rom_a_en, rom_a_addr); end
    step();
    done_valid = 1; done_thr = 0; done_halt = 1; look();
    n_chk++; if ({o0_pc, o0_instr} !== {12'h011, rom[12'h011]})
      begin n_fail++; $display("FAIL single_lane2 got pc=%h instr=%h exp pc=011 instr=%h", o0_pc, o0_instr, rom[12'h011]); end
    step();
  endtask

  task automatic test_dual_issue();
    apply_reset(); o0_ready = 0; o1_ready = 0;
    start_valid = 1; start_thr = 2; start_pc = 12'h020; look(); step();
    start_thr = 3; start_pc = 12'h030; look(); step();
    start_thr = 0; start_pc = 12'h000; done_valid = 1; done_thr = 2; done_pc = 12'h021; look(); step();
    idle_in(); start_valid = 1; start_thr = 1; start_pc = 12'h040; look();
    n_chk++; if ({rom_a_en, rom_b_en} !== 2'b00) begin n_fail++; $display("FAIL dual_blocked got en=%b%b exp 00", rom_a_en, rom_b_en); end
    step();
    idle_in(); o0_ready = 1; o1_ready = 1; look();
    n_chk++; if ({rom_a_en, rom_a_addr, rom_b_en, rom_b_addr} !== {1'b1, 12'h000, 1'b1, 12'h040})
      begin n_fail++; $display("FAIL dual_grant got a=%0b/%h b=%0b/%h exp a=1/000 b=1/040", rom_a_en, rom_a_addr, rom_b_en, rom_b_addr); end
    step();
    look();
    n_chk++; if ({o0_valid, o0_thr, o1_valid, o1_thr} !== {1'b1, 2'd0, 1'b1, 2'd1})
      begin n_fail++; $display("FAIL dual_lanes got v0=%0b t0=%0d v1=%0b t1=%0d exp 1 0 1 1", o0_valid, o0_thr, o1_valid, o1_thr); end
    n_chk++; if ({rom_a_en, rom_a_addr, rom_b_en} !== {1'b1, 12'h021, 1'b0})
      begin n_fail++; $display("FAIL dual_next_rr got a=%0b/%h b=%0b exp a=1/021 b=0", rom_a_en, rom_a_addr, rom_b_en); end
    step();
  endtask

  task automatic test_backpressure();
    o0_ready = 0; o1_ready = 0;
    for (int i = 0; i < 5; i++) begin
      idle_in();
      if (i == 0) begin done_valid = 1; done_thr = 0; done_pc = 12'h001; end
      if (i == 1) begin done_valid = 1; done_thr = 1; done_pc = 12'h041; end
      look();
      n_chk++; if ({rom_a_en, o0_valid, o0_pc} !== {1'b0, 1'b1, 12'h021})
        begin n_fail++; $display("FAIL bp_hold cyc %0d got en=%0b v=%0b pc=%h exp 0 1 021", i, rom_a_en, o0_valid, o0_pc); end
      n_chk++; if (o0_instr !== rom[12'h021]) begin n_fail++; $display("FAIL bp_instr cyc %0d got %h exp %h", i, o0_instr, rom[12'h021]); end
      if (i == 1) begin
        n_chk++; if ({rom_b_en, rom_b_addr} !== {1'b1, 12'h001})
          begin n_fail++; $display("FAIL bp_lane1 got en=%0b addr=%h exp 1/001", rom_b_en, rom_b_addr); end
      end
      step();
    end
    idle_in(); o0_ready = 1; look();
    n_chk++; if ({rom_a_en, rom_a_addr, rom_b_en} !== {1'b1, 12'h041, 1'b0})
      begin n_fail++; $display("FAIL bp_resume got a=%0b/%h b=%0b exp 1/041 0", rom_a_en, rom_a_addr, rom_b_en); end
    step();
  endtask

  task automatic test_halt_relaunch();
    o0_ready = 1; o1_ready = 1;
    idle_in(); done_valid = 1; done_thr = 3; done_halt = 1; start_valid = 1; start_thr = 3; start_pc = 12'h100; look();
    n_chk++; if (start_ready !== 1'b0) begin n_fail++; $display("FAIL halt_start_busy got %0b exp 0", start_ready); end
    step();
    idle_in(); start_valid = 1; start_thr = 3; start_pc = 12'h100; look();
    n_chk++; if ({thr_busy[3], start_ready} !== 2'b01)
      begin n_fail++; $display("FAIL halt_relaunch got busy3=%0b ready=%0b exp 0 1", thr_busy[3], start_ready); end
    step();
    idle_in(); start_valid = 1; start_thr = 2; start_pc = 12'h200; look();
    n_chk++; if (start_ready !== 1'b0) begin n_fail++; $display("FAIL halt_start_thr2 got %0b exp 0", start_ready); end
    n_chk++; if ({rom_a_en, rom_a_addr, rom_b_en} !== {1'b1, 12'h100, 1'b0})
      begin n_fail++; $display("FAIL halt_refetch got a=%0b/%h b=%0b exp 1/100 0", rom_a_en, rom_a_addr, rom_b_en); end
    step();
    idle_in(); look(); step();
  endtask

  task automatic test_error();
    idle_in(); done_valid = 1; done_thr = 2; done_halt = 1; look();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_initial got %0b exp 0", err); end
    step();
    idle_in(); done_valid = 1; done_thr = 2; done_pc = 12'h555; look(); step();
    for (int i = 0; i < 3; i++) begin
      idle_in(); look();
      n_chk++; if ({err, thr_busy, rom_a_en, rom_b_en} !== {1'b1, 4'b1011, 2'b00})
        begin n_fail++; $display("FAIL err_sticky cyc %0d got err=%0b busy=%b en=%b%b exp 1 1011 00", i, err, thr_busy, rom_a_en, rom_b_en); end
      step();
    end
  endtask

  task automatic test_async_reset();
    apply_reset(); o0_ready = 0; o1_ready = 0;
    start_valid = 1; start_thr = 0; start_pc = 12'h050; look(); step();
    start_thr = 1; start_pc = 12'h060; look(); step();
    start_thr = 2; start_pc = 12'h070; look(); step();
    idle_in(); o0_ready = 1; look();
    n_chk++; if ({o0_valid, o1_valid, rom_a_en} !== 3'b111)
      begin n_fail++; $display("FAIL arst_pre got v0=%0b v1=%0b en=%0b exp 111", o0_valid, o1_valid, rom_a_en); end
    #2; rst = 0; start_valid = 1; start_thr = 3; #1;
    n_chk++; if ({o0_valid, o1_valid, rom_a_en, rom_b_en, thr_busy, start_ready} !== '0)
      begin n_fail++; $display("FAIL arst_now got v=%0b%0b en=%0b%0b busy=%b sr=%0b exp all 0", o0_valid, o1_valid, rom_a_en, rom_b_en, thr_busy, start_ready); end
    model_reset(); idle_in();
    @(negedge clk); rst = 1;
  endtask

  task automatic test_random();
    int busy[$];
    bit [NT-1:0] eb;
    for (int i = 0; i < 600; i++) begin
      idle_in();
      o0_ready = ($urandom_range(0, 3) != 0);
      o1_ready = ($urandom_range(0, 3) != 0);
      start_valid = $urandom_range(0, 1);
      start_thr = TW'($urandom_range(0, NT-1));
      start_pc = AW'($urandom);
      busy = {};
      for (int k = 0; k < NT; k++) if (m_st[k] == 2) busy.push_back(k);
      if (busy.size() > 0 && $urandom_range(0, 1) == 1) begin
        done_valid = 1;
        done_thr = TW'(busy[$urandom_range(0, busy.size()-1)]);
        done_pc = AW'($urandom);
        done_halt = ($urandom_range(0, 5) == 0);
      end
      look();
      for (int k = 0; k < NT; k++) eb[k] = (m_st[k] != 0);
      n_chk++; if ({rom_a_en, rom_b_en} !== {e_en[0], e_en[1]})
        begin n_fail++; $display("FAIL rnd_en cyc %0d got %b%b exp %b%b", i, rom_a_en, rom_b_en, e_en[0], e_en[1]); end
      if (e_en[0]) begin
        n_chk++; if (rom_a_addr !== e_addr[0]) begin n_fail++; $display("FAIL rnd_addr_a cyc %0d got %h exp %h", i, rom_a_addr, e_addr[0]); end
      end
      if (e_en[1]) begin
        n_chk++; if (rom_b_addr !== e_addr[1]) begin n_fail++; $display("FAIL rnd_addr_b cyc %0d got %h exp %h", i, rom_b_addr, e_addr[1]); end
      end
      n_chk++; if ({start_ready, err, thr_busy, o0_valid, o1_valid} !== {e_sr, m_err, eb, m_v[0], m_v[1]})
        begin n_fail++; $display("FAIL rnd_status cyc %0d got sr=%0b err=%0b busy=%b v=%0b%0b exp %0b %0b %b %0b%0b", i, start_ready, err, thr_busy, o0_valid, o1_valid, e_sr, m_err, eb, m_v[0], m_v[1]); end
      if (m_v[0]) begin
        n_chk++; if ({o0_thr, o0_pc, o0_instr} !== {TW'(m_thr[0]), m_lpc[0], rom[m_lpc[0]]})
          begin n_fail++; $display("FAIL rnd_lane0 cyc %0d got thr=%0d pc=%h instr=%h exp %0d %h %h", i, o0_thr, o0_pc, o0_instr, m_thr[0], m_lpc[0], rom[m_lpc[0]]); end
      end
      if (m_v[1]) begin
        n_chk++; if ({o1_thr, o1_pc, o1_instr} !== {TW'(m_thr[1]), m_lpc[1], rom[m_lpc[1]]})
          begin n_fail++; $display("FAIL rnd_lane1 cyc %0d got thr=%0d pc=%h instr=%h exp %0d %h %h", i, o1_thr, o1_pc, o1_instr, m_thr[1], m_lpc[1], rom[m_lpc[1]]); end
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < RD; i++) rom[i] = {$urandom, $urandom};
    idle_in(); o0_ready = 1; o1_ready = 1;
    test_reset();
    test_single_thread();
    test_dual_issue();
    test_backpressure();
    test_halt_relaunch();
    test_error();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
